c_mem_drain: RTL and testbench

- Downstream stage of the 64x64 matrix-multiply controller.
- Once the multiply completes, it reads all 4096 22-bit results out of the result memory (rflp4096x22mx4, 1-cycle synchronous read) in address order.
- It streams them out on a valid/ready interface, tagging row-end and final words.
- A 2-entry buffer absorbs the memory read latency, so the block sustains 1 word/cycle and tolerates arbitrary backpressure.

---
 rtl/c_mem_drain_pkg.sv | 8 +
 rtl/c_drain_fifo2.sv | 38 +++
 rtl/c_mem_drain.sv | 79 +++++++
 tb/tb_c_mem_drain.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/c_mem_drain_pkg.sv
// c_mem_drain_pkg: result-memory geometry and drain FSM encoding shared by the matmul stages
package c_mem_drain_pkg;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 22;
    localparam int NWORDS  = 4096;
    localparam int ROW_LEN = 64;
    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
endpackage

// File: rtl/c_drain_fifo2.sv
// c_drain_fifo2: 2-entry synchronous FIFO absorbing the result-memory read latency
module c_drain_fifo2
    import c_mem_drain_pkg::*;
#(
    parameter int W = DATA_W + 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wp, rp;
    assign dout  = mem[rp];
    assign empty = count == 2'd0;
    assign full  = count == 2'd2;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/c_mem_drain.sv
// c_mem_drain: streams all result words out of the result memory in address order
// with row-end and last tags, at one word per cycle under arbitrary backpressure.
module c_mem_drain
    import c_mem_drain_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-3:0] mem_addr_row,
    output logic [1:0]        mem_addr_col,
    output logic              mem_nce,
    output logic              mem_nwrt,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last_row,
    output logic              m_last
);
    localparam int ROW_W = $clog2(ROW_LEN);
    state_t state;
    logic [ADDR_W-1:0] rd_addr, last_addr;
    logic inflight, issue, pop, empty, full;
    logic [1:0] count;
    logic [DATA_W+1:0] head;
    assign pop      = m_valid & m_ready;
    // an issue is allowed only if its word is guaranteed a buffer slot on arrival
    assign issue    = state == ISSUE && ({1'b0, count} + 3'(inflight)) < (3'd2 + 3'(pop));
    assign mem_nce  = ~(issue & rstn);
    assign mem_nwrt = 1'b1;
    assign {mem_addr_row, mem_addr_col} = issue ? rd_addr : last_addr;
    assign m_valid  = !empty;
    assign {m_last, m_last_row, m_data} = head;
    c_drain_fifo2 u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight),
        .pop   (pop),
        .din   ({last_addr == ADDR_W'(NWORDS - 1), &last_addr[ROW_W-1:0], mem_q}),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            rd_addr   <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            assert (!(inflight && full && !pop));
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                last_addr <= rd_addr;
                rd_addr   <= rd_addr + 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    state   <= ISSUE;
                    rd_addr <= '0;
                    busy    <= 1'b1;
                end
                ISSUE: if (issue && rd_addr == ADDR_W'(NWORDS - 1)) state <= FLUSH;
                FLUSH: if (pop && m_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c_mem_drain.sv
// tb_c_mem_drain: drains a modelled result memory under several ready patterns and
// scoreboards every accepted beat against the expected word/tag sequence.
module tb_c_mem_drain;
    import c_mem_drain_pkg::*;
    logic clk = 0, rstn = 0, start = 1, m_ready = 0;
    logic busy, done, mem_nce, mem_nwrt, m_valid, m_last_row, m_last;
    logic [ADDR_W-3:0] mem_addr_row;
    logic [1:0] mem_addr_col;
    logic [DATA_W-1:0] mem_q = '0, m_data;
    logic [DATA_W-1:0] mem [NWORDS];
    int total = 0, bad = 0, exp_i = 0, outst = 0;
    logic pend = 0, pstall = 0;
    logic [DATA_W+1:0] pword = '0;

    c_mem_drain dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
        .mem_addr_row(mem_addr_row), .mem_addr_col(mem_addr_col),
        .mem_nce(mem_nce), .mem_nwrt(mem_nwrt), .mem_q(mem_q),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last_row(m_last_row), .m_last(m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (!mem_nce) mem_q <= mem[{mem_addr_row, mem_addr_col}];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // stream monitor: scoreboard, hold-while-stalled, occupancy and done-timing model
    always @(negedge clk) begin
        chk("done_timing", 32'(done), 32'(pend));
        if (!rstn) begin
            outst = 0;
            pend = 0;
            pstall = 0;
        end else begin
            if (pstall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_word", 32'({m_last, m_last_row, m_data}), 32'(pword));
            end
            if (m_valid && m_ready) begin
                chk("beat_in_range", 32'(exp_i < NWORDS), 32'd1);
                if (exp_i < NWORDS)
                    chk("beat_word", 32'({m_last, m_last_row, m_data}),
                        32'({exp_i == NWORDS - 1, exp_i % ROW_LEN == ROW_LEN - 1, mem[exp_i]}));
                exp_i++;
            end
            outst = outst + int'(!mem_nce) - int'(m_valid && m_ready);
            chk("occupancy", 32'(outst <= 2 && outst >= 0), 32'd1);
            pend = m_valid && m_ready && m_last;
            pstall = m_valid && !m_ready;
            pword = {m_last, m_last_row, m_data};
        end
    end

    // mode 0: full rate; 1: random ready + stall at 500 + start at 1000;
    // 2: stall on final beat; 3: reset at beat 100
    task automatic run(input int mode, output int cyc, output int first_v);
        int stall = 0;
        bit s500 = 0, s1000 = 0, slast = 0;
        exp_i = 0;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        cyc = -1;
        first_v = -1;
        for (int n = 1; n <= 20000; n++) begin
            start = 0;
            if (mode == 1 && exp_i >= 1000 && !s1000) begin start = 1; s1000 = 1; end
            if (mode == 1 && exp_i >= 500 && !s500) begin stall = 20; s500 = 1; end
            if (mode == 2 && m_valid && m_last && !slast) begin stall = 10; slast = 1; end
            if (stall > 0) begin
                m_ready = 0;
                stall--;
                if (mode == 2) begin
                    chk("last_stall_done", 32'(done), 32'd0);
                    chk("last_stall_busy", 32'(busy), 32'd1);
                end
            end else m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 3 && exp_i == 100) begin
                rstn = 0;
                @(negedge clk) chk("rst_nce", 32'(mem_nce), 32'd1);
                @(posedge clk); #1 rstn = 1;
                chk("rst_valid", 32'(m_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                cyc = n;
                break;
            end
            @(posedge clk); #1;
            if (first_v < 0 && m_valid) first_v = n;
            if (done) begin cyc = n; break; end
        end
        start = 0;
        chk("run_bounded", 32'(cyc > 0), 32'd1);
        if (mode != 3) begin
            chk("beats_total", 32'(exp_i), 32'(NWORDS));
            chk("busy_at_done", 32'(busy), 32'd0);
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_valid", 32'(m_valid), 32'd0);
            chk("idle_nce", 32'(mem_nce), 32'd1);
        end
    endtask

    initial begin
        int cyc, fv;
        for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'(3 * i);
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_done", 32'(done), 32'd0);
            chk("reset_valid", 32'(m_valid), 32'd0);
            chk("reset_nce", 32'(mem_nce), 32'd1);
        end
        start = 0;
        rstn = 1;
        repeat (2) @(posedge clk);
        #1 chk("post_reset_idle", 32'({busy, m_valid}), 32'd0);
        chk("nwrt", 32'(mem_nwrt), 32'd1);

        run(0, cyc, fv);
        chk("full_first_valid", 32'(fv), 32'd2);
        chk("full_cycles", 32'(cyc), 32'(NWORDS + 2));

        run(1, cyc, fv);

        run(2, cyc, fv);
        chk("last_stall_cycles", 32'(cyc), 32'(NWORDS + 12));

        run(0, cyc, fv);
        chk("rerun_cycles", 32'(cyc), 32'(NWORDS + 2));

        run(3, cyc, fv);
        run(0, cyc, fv);
        chk("after_reset_first_valid", 32'(fv), 32'd2);
        chk("after_reset_cycles", 32'(cyc), 32'(NWORDS + 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
